// File: rtl/sdm_chan_seq_if.sv
// ----------------------------------------------------------------------------
// sdm_chan_seq_if
//   Channel-request bus between the channel-control register block (master)
//   and the divider configuration sequencer (slave).
//
//   cfg_valid   master -> slave  request valid (held until accepted)
//   cfg_ready   slave  -> master sequencer can accept a request
//   cfg_n       master -> slave  target integer divide (6 bits)
//   cfg_frac    master -> slave  target fraction (16 bits)
//   cfg_nc_en   master -> slave  enable noise cancellation after settle
//   cfg_nc_coef master -> slave  noise-cancel coefficient (15 bits)
// ----------------------------------------------------------------------------
interface sdm_chan_seq_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [5:0]  cfg_n;
    logic [15:0] cfg_frac;
    logic        cfg_nc_en;
    logic [14:0] cfg_nc_coef;

    modport master (
        output cfg_valid,
        output cfg_n,
        output cfg_frac,
        output cfg_nc_en,
        output cfg_nc_coef,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_n,
        input  cfg_frac,
        input  cfg_nc_en,
        input  cfg_nc_coef,
        output cfg_ready
    );
endinterface

// File: rtl/sdm_chan_seq.sv
// ----------------------------------------------------------------------------
// sdm_chan_seq
//   Configuration sequencer for the sigma-delta fractional-N divider loop.
//   Accepts a channel request, ramps the combined divide word {N, frac} to the
//   target in steps of at most RAMP_STEP per clock, waits SETTLE_CYC clocks,
//   optionally enables noise cancellation for NC_CYC clocks, then reports lock.
//
//   Ports
//     clk_dlf        in   loop-filter clock, rising edge
//     rstn           in   asynchronous active-low reset
//     cfg            slave modport of sdm_chan_seq_if (request handshake)
//     N              out  integer divide to the divider loop
//     sdm_in         out  fraction to the SDM
//     sdm_nc_enable  out  noise-cancel enable to the loop
//     sdm_nc_in      out  noise-cancel coefficient to the loop
//     busy           out  high while ramping / settling / in noise-cancel wait
//     locked         out  high once the sequence has completed
//     cfg_err        out  one-cycle pulse when an out-of-range request is
//                         rejected
// ----------------------------------------------------------------------------
module sdm_chan_seq #(
    parameter int unsigned RAMP_STEP  = 1024,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned NC_CYC     = 16,
    parameter int unsigned N_MIN      = 8,
    parameter int unsigned N_MAX      = 62,
    parameter int unsigned N_RST      = 31,
    parameter int unsigned FRAC_RST   = 26625
) (
    input  logic                clk_dlf,
    input  logic                rstn,
    sdm_chan_seq_if.slave       cfg,
    output logic [5:0]          N,
    output logic [15:0]         sdm_in,
    output logic                sdm_nc_enable,
    output logic [14:0]         sdm_nc_in,
    output logic                busy,
    output logic                locked,
    output logic                cfg_err
);

    localparam int unsigned CNT_MAX  = (SETTLE_CYC > NC_CYC) ? SETTLE_CYC : NC_CYC;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [21:0] RST_WORD = {6'(N_RST), 16'(FRAC_RST)};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMP,
        S_SETTLE,
        S_NC_ON,
        S_LOCKED
    } state_t;

    state_t             state_q, state_d;
    logic [21:0]        cur_q, cur_d;
    logic [21:0]        tgt_q, tgt_d;
    logic               nc_en_q, nc_en_d;
    logic [14:0]        coef_q, coef_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               nce_q, nce_d;
    logic [14:0]        nci_q, nci_d;
    logic               err_q, err_d;

    logic               accept;
    logic               req_in_range;
    logic [21:0]        ramp_word;

    // One ramp step: move toward tgt by min(|tgt-cur|, RAMP_STEP). The step is
    // clamped to the remaining distance, so the word never overshoots or wraps.
    function automatic logic [21:0] ramp_next(input logic [21:0] cur,
                                              input logic [21:0] tgt);
        logic signed [22:0] d;
        logic [22:0]        mag;
        logic [21:0]        step;
        d    = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = d[22] ? 23'(-d) : 23'(d);
        step = (mag > 23'(RAMP_STEP)) ? 22'(RAMP_STEP) : mag[21:0];
        return d[22] ? (cur - step) : (cur + step);
    endfunction

    assign cfg.cfg_ready = (state_q == S_IDLE) || (state_q == S_LOCKED);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign req_in_range  = (cfg.cfg_n >= 6'(N_MIN)) && (cfg.cfg_n <= 6'(N_MAX));
    assign ramp_word     = ramp_next(cur_q, tgt_q);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        nc_en_d = nc_en_q;
        coef_d  = coef_q;
        cnt_d   = cnt_q;
        nce_d   = nce_q;
        nci_d   = nci_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE, S_LOCKED: begin
                if (accept) begin
                    if (!req_in_range) begin
                        // Rejected requests leave everything else untouched.
                        err_d = 1'b1;
                    end else begin
                        tgt_d   = {cfg.cfg_n, cfg.cfg_frac};
                        nc_en_d = cfg.cfg_nc_en;
                        coef_d  = cfg.cfg_nc_coef;
                        nce_d   = 1'b0;
                        nci_d   = '0;
                        state_d = S_RAMP;
                    end
                end
            end
            S_RAMP: begin
                // A zero-distance request still spends one cycle here.
                cur_d = ramp_word;
                if (ramp_word == tgt_q) begin
                    state_d = S_SETTLE;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    if (nc_en_q) begin
                        // Enable and coefficient land with the first NC_ON cycle.
                        state_d = S_NC_ON;
                        cnt_d   = CNT_W'(NC_CYC - 1);
                        nce_d   = 1'b1;
                        nci_d   = coef_q;
                    end else begin
                        state_d = S_LOCKED;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_NC_ON: begin
                if (cnt_q == '0) begin
                    state_d = S_LOCKED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_dlf or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cur_q   <= RST_WORD;
            tgt_q   <= RST_WORD;
            nc_en_q <= 1'b0;
            coef_q  <= '0;
            cnt_q   <= '0;
            nce_q   <= 1'b0;
            nci_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            nc_en_q <= nc_en_d;
            coef_q  <= coef_d;
            cnt_q   <= cnt_d;
            nce_q   <= nce_d;
            nci_q   <= nci_d;
            err_q   <= err_d;
        end
    end

    assign N             = cur_q[21:16];
    assign sdm_in        = cur_q[15:0];
    assign sdm_nc_enable = nce_q;
    assign sdm_nc_in     = nci_q;
    assign cfg_err       = err_q;
    assign busy          = (state_q == S_RAMP) || (state_q == S_SETTLE) || (state_q == S_NC_ON);
    assign locked        = (state_q == S_LOCKED);

endmodule

// File: tb/tb_sdm_chan_seq.sv
module tb_sdm_chan_seq;

    localparam int RAMP   = 1024;
    localparam int SETTLE = 64;
    localparam int NCC    = 16;
    localparam logic [21:0] RST_WORD = {6'd31, 16'd26625};

    logic clk_dlf;
    logic rstn;

    logic [5:0]  N;
    logic [15:0] sdm_in;
    logic        sdm_nc_enable;
    logic [14:0] sdm_nc_in;
    logic        busy;
    logic        locked;
    logic        cfg_err;

    sdm_chan_seq_if cfg_if();

    sdm_chan_seq dut (
        .clk_dlf      (clk_dlf),
        .rstn         (rstn),
        .cfg          (cfg_if),
        .N            (N),
        .sdm_in       (sdm_in),
        .sdm_nc_enable(sdm_nc_enable),
        .sdm_nc_in    (sdm_nc_in),
        .busy         (busy),
        .locked       (locked),
        .cfg_err      (cfg_err)
    );

    initial clk_dlf = 1'b0;
    always #5 clk_dlf = ~clk_dlf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the loop outputs should currently hold.
    logic [21:0] m_word   = RST_WORD;
    bit          m_locked = 1'b0;
    bit          m_nc     = 1'b0;
    logic [14:0] m_coef   = '0;

    function automatic int ramp_cycles(input logic [21:0] from, input logic [21:0] to);
        int ad;
        ad = int'(to) - int'(from);
        if (ad < 0) ad = -ad;
        return (ad == 0) ? 1 : (ad + RAMP - 1) / RAMP;
    endfunction

    // Drive a request at the current sample point and let one edge accept it.
    task automatic send(input logic [5:0] n, input logic [15:0] f,
                        input bit nc, input logic [14:0] coef);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_n       = n;
        cfg_if.cfg_frac    = f;
        cfg_if.cfg_nc_en   = nc;
        cfg_if.cfg_nc_coef = coef;
        n_tests++;
        if (cfg_if.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready got=%b want=1", cfg_if.cfg_ready);
        end
        @(posedge clk_dlf); #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Follow an accepted request from T+1 to its first LOCKED cycle, comparing
    // every cycle against the closed-form trajectory of the ramp/settle/nc plan.
    task automatic track(input string name, input logic [21:0] tgt,
                         input bit nc, input logic [14:0] coef);
        int r, last, k, dir;
        logic [21:0] start, ew;
        bit eb, el, en;
        logic [14:0] ec;
        start = m_word;
        r     = ramp_cycles(start, tgt);
        last  = r + SETTLE + (nc ? NCC : 0) + 1;
        dir   = (int'(tgt) >= int'(start)) ? 1 : -1;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) begin
                @(posedge clk_dlf); #1;
            end
            k  = (c - 1 < r) ? c - 1 : r;
            ew = (k >= r) ? tgt : 22'(int'(start) + dir * RAMP * k);
            eb = (c < last);
            el = (c == last);
            en = nc && (c >= r + SETTLE + 1);
            ec = en ? coef : 15'd0;
            n_tests++;
            if ({busy, locked, cfg_if.cfg_ready, cfg_err, N, sdm_in, sdm_nc_enable, sdm_nc_in}
                !== {eb, el, ~eb, 1'b0, ew, en, ec}) begin
                n_fail++;
                $display("FAIL %s c=%0d got busy=%b lk=%b rdy=%b err=%b word=%h nce=%b nci=%h want busy=%b lk=%b rdy=%b err=0 word=%h nce=%b nci=%h",
                         name, c, busy, locked, cfg_if.cfg_ready, cfg_err, {N, sdm_in},
                         sdm_nc_enable, sdm_nc_in, eb, el, ~eb, ew, en, ec);
            end
        end
        m_word   = tgt;
        m_locked = 1'b1;
        m_nc     = nc;
        m_coef   = nc ? coef : 15'd0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_n = '0; cfg_if.cfg_frac = '0;
        cfg_if.cfg_nc_en = 1'b0; cfg_if.cfg_nc_coef = '0;
        #2 rstn = 1'b0;
        repeat (10) @(posedge clk_dlf);
        #1;
        n_tests++;
        if ({N, sdm_in, sdm_nc_enable, sdm_nc_in, cfg_if.cfg_ready, busy, locked, cfg_err}
            !== {6'd31, 16'd26625, 1'b0, 15'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold got N=%0d frac=%0d nce=%b rdy=%b busy=%b lk=%b err=%b want N=31 frac=26625 nce=0 rdy=1 busy=0 lk=0 err=0",
                     N, sdm_in, sdm_nc_enable, cfg_if.cfg_ready, busy, locked, cfg_err);
        end
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_dlf); #1;
            n_tests++;
            if ({N, sdm_in, sdm_nc_enable, cfg_if.cfg_ready, busy, locked, cfg_err}
                !== {6'd31, 16'd26625, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_stable i=%0d got N=%0d frac=%0d rdy=%b busy=%b lk=%b want N=31 frac=26625 rdy=1 busy=0 lk=0",
                         i, N, sdm_in, cfg_if.cfg_ready, busy, locked);
            end
        end
        m_word = RST_WORD; m_locked = 1'b0; m_nc = 1'b0; m_coef = '0;
    endtask

    task automatic test_up_ramp();
        n_tests++;
        if (ramp_cycles(m_word, {6'd32, 16'd0}) != 38) begin
            n_fail++;
            $display("FAIL up_ramp_len got=%0d want=38", ramp_cycles(m_word, {6'd32, 16'd0}));
        end
        send(6'd32, 16'd0, 1'b0, 15'h7fff);
        track("up_ramp", {6'd32, 16'd0}, 1'b0, 15'h7fff);
    endtask

    task automatic test_down_nc();
        send(6'd31, 16'd65535, 1'b1, 15'h1234);
        track("down_nc", {6'd31, 16'd65535}, 1'b1, 15'h1234);
    endtask

    task automatic test_reject();
        logic [5:0] bad [4] = '{6'd5, 6'd63, 6'd0, 6'd7};
        for (int i = 0; i < 4; i++) begin
            send(bad[i], 16'(i * 777), 1'b1, 15'h0abc);
            n_tests++;
            if ({cfg_err, N, sdm_in, locked, busy, sdm_nc_enable, sdm_nc_in}
                !== {1'b1, m_word, m_locked, 1'b0, m_nc, m_coef}) begin
                n_fail++;
                $display("FAIL reject_pulse n=%0d got err=%b word=%h lk=%b busy=%b nce=%b want err=1 word=%h lk=%b busy=0 nce=%b",
                         bad[i], cfg_err, {N, sdm_in}, locked, busy, sdm_nc_enable, m_word, m_locked, m_nc);
            end
            @(posedge clk_dlf); #1;
            n_tests++;
            if ({cfg_err, N, sdm_in, locked, busy} !== {1'b0, m_word, m_locked, 1'b0}) begin
                n_fail++;
                $display("FAIL reject_after n=%0d got err=%b word=%h lk=%b want err=0 word=%h lk=%b",
                         bad[i], cfg_err, {N, sdm_in}, locked, m_word, m_locked);
            end
        end
    endtask

    task automatic test_boundaries();
        send(6'd62, 16'd65535, 1'b0, 15'd0);
        track("max_word", {6'd62, 16'd65535}, 1'b0, 15'd0);
        send(6'd8, 16'd0, 1'b1, 15'h4001);
        track("min_word", {6'd8, 16'd0}, 1'b1, 15'h4001);
        send(m_word[21:16], m_word[15:0], 1'b0, 15'd3);
        track("same_word", m_word, 1'b0, 15'd3);
    endtask

    task automatic test_back_to_back();
        logic [21:0] wa, wb;
        wa = {6'd9, 16'(($urandom % 4096))};
        wb = {6'd11, 16'($urandom)};
        send(wa[21:16], wa[15:0], 1'b0, 15'd0);
        // Second request held through the whole busy period.
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_n       = wb[21:16];
        cfg_if.cfg_frac    = wb[15:0];
        cfg_if.cfg_nc_en   = 1'b1;
        cfg_if.cfg_nc_coef = 15'h2222;
        track("b2b_first", wa, 1'b0, 15'd0);
        @(posedge clk_dlf); #1;
        cfg_if.cfg_valid = 1'b0;
        track("b2b_second", wb, 1'b1, 15'h2222);
    endtask

    task automatic test_abort();
        int r;
        logic [21:0] w;
        w = {6'd20, 16'($urandom)};
        r = ramp_cycles(m_word, w);
        send(w[21:16], w[15:0], 1'b1, 15'h5555);
        repeat (r + 10) @(posedge clk_dlf);
        #1;
        n_tests++;
        if ({busy, N, sdm_in} !== {1'b1, w}) begin
            n_fail++;
            $display("FAIL abort_settle got busy=%b word=%h want busy=1 word=%h", busy, {N, sdm_in}, w);
        end
        rstn = 1'b0;
        #1;
        n_tests++;
        if ({N, sdm_in, busy, locked, cfg_if.cfg_ready, sdm_nc_enable, sdm_nc_in}
            !== {RST_WORD, 1'b0, 1'b0, 1'b1, 1'b0, 15'd0}) begin
            n_fail++;
            $display("FAIL abort_reset got word=%h busy=%b lk=%b rdy=%b nce=%b want word=%h busy=0 lk=0 rdy=1 nce=0",
                     {N, sdm_in}, busy, locked, cfg_if.cfg_ready, sdm_nc_enable, RST_WORD);
        end
        repeat (2) @(posedge clk_dlf);
        #1 rstn = 1'b1;
        @(posedge clk_dlf); #1;
        n_tests++;
        if ({N, sdm_in, busy, locked} !== {RST_WORD, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_release got word=%h busy=%b lk=%b want word=%h busy=0 lk=0",
                     {N, sdm_in}, busy, locked, RST_WORD);
        end
        m_word = RST_WORD; m_locked = 1'b0; m_nc = 1'b0; m_coef = '0;
    endtask

    task automatic test_random();
        logic [5:0]  n;
        logic [15:0] f;
        bit          nc;
        logic [14:0] cf;
        for (int i = 0; i < 8; i++) begin
            n  = 6'($urandom_range(0, 63));
            f  = 16'($urandom);
            nc = 1'($urandom);
            cf = 15'($urandom);
            send(n, f, nc, cf);
            if (n >= 6'd8 && n <= 6'd62) begin
                track("random", {n, f}, nc, cf);
            end else begin
                n_tests++;
                if ({cfg_err, N, sdm_in, busy, locked} !== {1'b1, m_word, 1'b0, m_locked}) begin
                    n_fail++;
                    $display("FAIL random_reject n=%0d got err=%b word=%h busy=%b lk=%b want err=1 word=%h busy=0 lk=%b",
                             n, cfg_err, {N, sdm_in}, busy, locked, m_word, m_locked);
                end
                @(posedge clk_dlf); #1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_nc();
        test_reject();
        test_boundaries();
        test_back_to_back();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
